// File: rtl/cpu_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch slice of the core.
package cpu_fetch_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] NOP          = 32'h0000_0000;

endpackage

// File: rtl/fetch_inst_buffer.sv
// Holds the fetched word while ID stalls, since the SRAM output
// is only guaranteed for one cycle after a request.
module fetch_inst_buffer
    import cpu_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        buf_release,
    input  logic [31:0] rdata,
    output logic [31:0] inst
);

    logic        buf_valid;
    logic [31:0] inst_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            inst_buf  <= NOP;
        end else if (buf_release) begin
            buf_valid <= 1'b0;
        end else if (capture && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= rdata;
        end
    end

    assign inst = buf_valid ? inst_buf : rdata;

endmodule

// File: rtl/cpu_fetch_stage.sv
// Instruction-fetch stage: next-PC selection, inst SRAM request,
// and redirect capture while ID back-pressures.
module cpu_fetch_stage
    import cpu_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allow_in,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        br_pend;
    logic [31:0] br_pend_target;
    logic        fs_allow_in;
    logic [31:0] next_pc;
    logic [31:0] buf_inst;

    assign fs_allow_in = !fs_valid || id_allow_in;

    // A fresh redirect overrides one already parked during a stall.
    assign next_pc = br_taken ? br_target
                   : br_pend  ? br_pend_target
                   : fs_pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_valid       <= 1'b0;
            fs_pc          <= RESET_PC - PC_STEP;
            br_pend        <= 1'b0;
            br_pend_target <= 32'h0;
        end else if (fs_allow_in) begin
            fs_valid <= 1'b1;
            fs_pc    <= next_pc;
            br_pend  <= 1'b0;
        end else if (br_taken) begin
            br_pend        <= 1'b1;
            br_pend_target <= br_target;
        end
    end

    fetch_inst_buffer u_buf (
        .clk         (clk),
        .rst         (rst),
        .capture     (fs_valid && !fs_allow_in),
        .buf_release (fs_allow_in),
        .rdata       (inst_sram_rdata),
        .inst        (buf_inst)
    );

    assign inst_sram_en    = !rst && fs_allow_in;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = next_pc;
    assign inst_sram_wdata = NOP;

    assign if_valid = fs_valid;
    assign if_pc    = fs_pc;
    assign if_inst  = rst ? NOP : buf_inst;

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Directed bench for cpu_fetch_stage with a 1-cycle SRAM model.
module tb_cpu_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_allow_in;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    logic [31:0] sram_q = 32'h0;
    logic        garbage;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (inst_sram_en) sram_q <= ~inst_sram_addr;

    assign inst_sram_rdata = garbage ? 32'hDEAD_BEEF : sram_q;

    cpu_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .id_allow_in     (id_allow_in),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        br_taken = 1'b0;
        br_target = 32'h0;
        id_allow_in = 1'b1;
        garbage = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_en", 32'(inst_sram_en), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'hBFBF_FFFC);
        chk("rst_inst", if_inst, 32'h0);
        chk("wen", 32'(inst_sram_wen), 32'd0);
        chk("wdata", inst_sram_wdata, 32'h0);

        rst = 1'b0;
        garbage = 1'b0;
        #1;
        chk("c0_en", 32'(inst_sram_en), 32'd1);
        chk("c0_addr", inst_sram_addr, 32'hBFC0_0000);
        chk("c0_valid", 32'(if_valid), 32'd0);

        cyc();
        chk("c1_valid", 32'(if_valid), 32'd1);
        chk("c1_pc", if_pc, 32'hBFC0_0000);
        chk("c1_inst", if_inst, 32'h403F_FFFF);
        chk("c1_addr", inst_sram_addr, 32'hBFC0_0004);

        cyc();
        chk("c2_pc", if_pc, 32'hBFC0_0004);
        chk("c2_inst", if_inst, 32'h403F_FFFB);
        chk("c2_addr", inst_sram_addr, 32'hBFC0_0008);

        // stall three cycles with garbage on the SRAM bus
        id_allow_in = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_en", 32'(inst_sram_en), 32'd0);
            chk("stall_pc", if_pc, 32'hBFC0_0004);
            chk("stall_inst", if_inst, 32'h403F_FFFB);
            cyc();
            garbage = 1'b1;
            #1;
        end
        id_allow_in = 1'b1;
        #1;
        chk("rel_inst", if_inst, 32'h403F_FFFB);
        garbage = 1'b0;
        #1;
        chk("rel_en", 32'(inst_sram_en), 32'd1);
        chk("rel_addr", inst_sram_addr, 32'hBFC0_0008);

        cyc();
        chk("c3_pc", if_pc, 32'hBFC0_0008);
        chk("c3_inst", if_inst, 32'h403F_FFF7);
        br_taken = 1'b1;
        br_target = 32'hBFC0_0100;
        #1;
        chk("br_addr", inst_sram_addr, 32'hBFC0_0100);
        chk("br_en", 32'(inst_sram_en), 32'd1);

        cyc();
        br_taken = 1'b0;
        #1;
        chk("br_pc", if_pc, 32'hBFC0_0100);
        chk("br_inst", if_inst, 32'h403F_FEFF);
        chk("br_next", inst_sram_addr, 32'hBFC0_0104);

        // redirect while stalled
        id_allow_in = 1'b0;
        br_taken = 1'b1;
        br_target = 32'hBFC0_0200;
        #1;
        chk("sbr_en", 32'(inst_sram_en), 32'd0);
        cyc();
        br_taken = 1'b0;
        #1;
        chk("sbr_pend", inst_sram_addr, 32'hBFC0_0200);
        chk("sbr_pc", if_pc, 32'hBFC0_0100);
        cyc();
        chk("sbr_pc2", if_pc, 32'hBFC0_0100);
        cyc();
        id_allow_in = 1'b1;
        #1;
        chk("sbr_rel_en", 32'(inst_sram_en), 32'd1);
        chk("sbr_rel_addr", inst_sram_addr, 32'hBFC0_0200);
        chk("sbr_rel_inst", if_inst, 32'h403F_FEFF);
        cyc();
        chk("sbr_pc3", if_pc, 32'hBFC0_0200);
        chk("sbr_inst3", if_inst, 32'h403F_FDFF);

        // pending redirect overwritten while still stalled
        id_allow_in = 1'b0;
        br_taken = 1'b1;
        br_target = 32'hBFC0_0400;
        cyc();
        br_target = 32'hBFC0_0300;
        #1;
        chk("b2b_new", inst_sram_addr, 32'hBFC0_0300);
        cyc();
        br_taken = 1'b0;
        #1;
        chk("b2b_latch", inst_sram_addr, 32'hBFC0_0300);
        cyc();
        id_allow_in = 1'b1;
        #1;
        chk("b2b_rel", inst_sram_addr, 32'hBFC0_0300);
        chk("b2b_pc", if_pc, 32'hBFC0_0200);
        cyc();
        chk("b2b_pc2", if_pc, 32'hBFC0_0300);

        // async reset mid-stall with a redirect pending
        id_allow_in = 1'b0;
        br_taken = 1'b1;
        br_target = 32'hBFC0_0500;
        cyc();
        br_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 32'(if_valid), 32'd0);
        chk("mrst_pc", if_pc, 32'hBFBF_FFFC);
        chk("mrst_inst", if_inst, 32'h0);
        chk("mrst_en", 32'(inst_sram_en), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_addr", inst_sram_addr, 32'hBFC0_0000);
        chk("mrst_en2", 32'(inst_sram_en), 32'd1);
        cyc();
        id_allow_in = 1'b1;
        #1;
        chk("mrst_pc2", if_pc, 32'hBFC0_0000);
        chk("mrst_valid2", 32'(if_valid), 32'd1);

        // wrap-around and misaligned pass-through
        br_taken = 1'b1;
        br_target = 32'hFFFF_FFFC;
        #1;
        chk("wrap_tgt", inst_sram_addr, 32'hFFFF_FFFC);
        cyc();
        br_taken = 1'b0;
        #1;
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
        br_taken = 1'b1;
        br_target = 32'h0000_0102;
        #1;
        chk("mis_addr", inst_sram_addr, 32'h0000_0102);
        cyc();
        br_taken = 1'b0;
        #1;
        chk("mis_pc", if_pc, 32'h0000_0102);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
